loading_table_controller: RTL and testbench

Sequencer and arbiter that owns all ports of the 32-entry register loading table, which tracks outstanding loads per destination register. It shares the table's single write port between the load-issue requester (execute stage) and the load-retire requester (memory response path). It serves hazard lookups from decode and runs a bulk flush sequence that clears every entry without a global reset.

---
 rtl/loading_table_controller.sv | 124 ++++++++++++
 tb/tb_loading_table_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loading_table_controller.sv
// Arbiter/sequencer owning the register loading table ports: issue/retire write arbitration,
// hazard lookup and bulk flush. Define LOADING_TABLE_BYPASS_EN for same-cycle write-to-lookup bypass.
module loading_table_controller #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [DEPTH-1:0] issue_index,
  input  logic [WIDTH-2:0] issue_tag,
  output logic             issue_ready,
  input  logic             retire_valid,
  input  logic [DEPTH-1:0] retire_index,
  output logic             retire_ready,
  input  logic             lookup_valid,
  input  logic [DEPTH-1:0] lookup_index,
  output logic             lookup_pending,
  output logic [WIDTH-2:0] lookup_tag,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done,
  output logic             tbl_read_enable,
  output logic [DEPTH-1:0] tbl_read_index,
  input  logic [WIDTH-1:0] tbl_read_data,
  output logic             tbl_write_enable,
  output logic [DEPTH-1:0] tbl_write_index,
  output logic [WIDTH-1:0] tbl_write_data
);

  localparam int NUM_WORDS = 2 ** DEPTH;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t           state, state_next;
  logic [DEPTH-1:0] counter;
  logic             prio_issue;
  logic             grant_issue, grant_retire, contested;
  logic [WIDTH-1:0] lookup_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      prio_issue <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FLUSH) counter <= counter + 1'b1;
      else                counter <= '0;
      // Only a contested grant hands priority to the other requester.
      if (contested) prio_issue <= ~prio_issue;
    end
  end

  always_comb begin
    state_next       = state;
    grant_issue      = 1'b0;
    grant_retire     = 1'b0;
    contested        = 1'b0;
    busy             = 1'b0;
    flush_done       = 1'b0;
    tbl_write_enable = 1'b0;
    tbl_write_index  = '0;
    tbl_write_data   = '0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
        end else begin
          contested = issue_valid && retire_valid;
          if (contested) begin
            grant_issue  = prio_issue;
            grant_retire = !prio_issue;
          end else begin
            grant_issue  = issue_valid;
            grant_retire = retire_valid;
          end
        end
      end
      FLUSH: begin
        busy             = 1'b1;
        tbl_write_enable = 1'b1;
        tbl_write_index  = counter;
        if (counter == DEPTH'(NUM_WORDS - 1)) state_next = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (grant_issue) begin
      tbl_write_enable = 1'b1;
      tbl_write_index  = issue_index;
      tbl_write_data   = {1'b1, issue_tag};
    end else if (grant_retire) begin
      tbl_write_enable = 1'b1;
      tbl_write_index  = retire_index;
      tbl_write_data   = '0;
    end
  end

  assign issue_ready     = grant_issue;
  assign retire_ready    = grant_retire;
  assign tbl_read_enable = lookup_valid && (state == IDLE);
  assign tbl_read_index  = lookup_index;

  // Masking the read data keeps an undriven table bus out of the lookup outputs.
  always_comb begin
    lookup_word = tbl_read_enable ? tbl_read_data : '0;
`ifdef LOADING_TABLE_BYPASS_EN
    if (tbl_read_enable && tbl_write_enable && (tbl_write_index == lookup_index))
      lookup_word = tbl_write_data;
`endif
    if (state != IDLE) begin
      lookup_pending = 1'b1;
      lookup_tag     = '0;
    end else begin
      lookup_pending = lookup_word[WIDTH-1];
      lookup_tag     = lookup_word[WIDTH-2:0];
    end
  end

endmodule

// File: tb/tb_loading_table_controller.sv
// Scoreboard bench for loading_table_controller with a behavioural table model;
// follows LOADING_TABLE_BYPASS_EN to choose same-cycle lookup expectations.
module tb_loading_table_controller;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int NW    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid, retire_valid, lookup_valid, flush_req;
  logic [DEPTH-1:0] issue_index, retire_index, lookup_index;
  logic [WIDTH-2:0] issue_tag;
  logic             issue_ready, retire_ready, lookup_pending, busy, flush_done;
  logic [WIDTH-2:0] lookup_tag;
  logic             tbl_read_enable, tbl_write_enable;
  logic [DEPTH-1:0] tbl_read_index, tbl_write_index;
  logic [WIDTH-1:0] tbl_write_data;
  wire  [WIDTH-1:0] tbl_read_data;

  logic [WIDTH-1:0] mem [NW];
  logic             tb_init;

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] wr_q [$];
  logic [31:0] lk_q [$];

  always #5 clk = ~clk;

  loading_table_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_index(issue_index), .issue_tag(issue_tag),
    .issue_ready(issue_ready),
    .retire_valid(retire_valid), .retire_index(retire_index), .retire_ready(retire_ready),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index),
    .lookup_pending(lookup_pending), .lookup_tag(lookup_tag),
    .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
    .tbl_read_enable(tbl_read_enable), .tbl_read_index(tbl_read_index),
    .tbl_read_data(tbl_read_data),
    .tbl_write_enable(tbl_write_enable), .tbl_write_index(tbl_write_index),
    .tbl_write_data(tbl_write_data)
  );

  // Table model: synchronous write, combinational read, bus floats when not enabled.
  assign tbl_read_data = tbl_read_enable ? mem[tbl_read_index] : {WIDTH{1'bz}};

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < NW; i++) mem[i] <= '0;
    end else if (tbl_write_enable) begin
      mem[tbl_write_index] <= tbl_write_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] wr(input logic ir, input logic rr, input logic b,
                                     input logic [4:0] idx, input logic [31:0] d);
    return {ir, rr, b, idx, d};
  endfunction

  // Monitor: every table write and every lookup is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (tbl_write_enable) begin
        if (wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL write_unexpected: got idx %0d data %h required no write at %0t",
                   tbl_write_index, tbl_write_data, $time);
        end else begin
          chk($sformatf("write_idx%0d", tbl_write_index),
              {issue_ready, retire_ready, busy, tbl_write_index, tbl_write_data},
              wr_q.pop_front());
        end
      end
      if (lookup_valid) begin
        if (lk_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL lookup_unexpected: got idx %0d required no lookup at %0t",
                   lookup_index, $time);
        end else begin
          chk($sformatf("lookup_idx%0d", lookup_index), {lookup_pending, lookup_tag},
              lk_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [4:0] idx, input logic [31:0] exp);
    lookup_valid = 1'b1;
    lookup_index = idx;
    lk_q.push_back(exp);
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no completion required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fd_count;
    reset = 1'b1; tb_init = 1'b1;
    issue_valid = 1'b0; retire_valid = 1'b0; lookup_valid = 1'b0; flush_req = 1'b0;
    issue_index = '0; retire_index = '0; lookup_index = '0; issue_tag = '0;
    @(negedge clk);
    chk("reset_outputs", {issue_ready, retire_ready, busy, flush_done, tbl_write_enable,
                          tbl_read_enable, lookup_pending, lookup_tag}, '0);
    tick();
    reset = 1'b0; tb_init = 1'b0;

    // Lone issue, then lookup sees it next cycle.
    issue_valid = 1'b1; issue_index = 5'd3; issue_tag = 31'h15;
    wr_q.push_back(wr(1, 0, 0, 5'd3, {1'b1, 31'h15}));
    tick();
    issue_valid = 1'b0;
    do_lookup(5'd3, {1'b1, 31'h15});

    // Contention from reset: retire first, then issue alone.
    issue_valid = 1'b1; issue_index = 5'd4; issue_tag = 31'h11;
    retire_valid = 1'b1; retire_index = 5'd3;
    wr_q.push_back(wr(0, 1, 0, 5'd3, 32'h0));
    tick();
    retire_valid = 1'b0;
    wr_q.push_back(wr(1, 0, 0, 5'd4, {1'b1, 31'h11}));
    tick();

    // Sustained contention alternates, pointer now favours issue.
    issue_index = 5'd5; issue_tag = 31'h01;
    retire_valid = 1'b1; retire_index = 5'd6;
    wr_q.push_back(wr(1, 0, 0, 5'd5, {1'b1, 31'h01}));
    wr_q.push_back(wr(0, 1, 0, 5'd6, 32'h0));
    wr_q.push_back(wr(1, 0, 0, 5'd5, {1'b1, 31'h01}));
    wr_q.push_back(wr(0, 1, 0, 5'd6, 32'h0));
    repeat (4) tick();
    issue_valid = 1'b0; retire_valid = 1'b0;
    do_lookup(5'd4, {1'b1, 31'h11});
    do_lookup(5'd3, 32'h0);
    do_lookup(5'd5, {1'b1, 31'h01});

    // Same-cycle write and lookup to one index.
    issue_valid = 1'b1; issue_index = 5'd7; issue_tag = 31'h2A;
    wr_q.push_back(wr(1, 0, 0, 5'd7, {1'b1, 31'h2A}));
`ifdef LOADING_TABLE_BYPASS_EN
    do_lookup(5'd7, {1'b1, 31'h2A});
`else
    do_lookup(5'd7, 32'h0);
`endif
    issue_valid = 1'b0;
    do_lookup(5'd7, {1'b1, 31'h2A});
    retire_valid = 1'b1; retire_index = 5'd7;
    wr_q.push_back(wr(0, 1, 0, 5'd7, 32'h0));
`ifdef LOADING_TABLE_BYPASS_EN
    do_lookup(5'd7, 32'h0);
`else
    do_lookup(5'd7, {1'b1, 31'h2A});
`endif
    retire_valid = 1'b0;
    do_lookup(5'd7, 32'h0);

    // Fill every entry, then flush with an issue held through it.
    for (int i = 0; i < NW; i++) begin
      issue_valid = 1'b1; issue_index = 5'(i); issue_tag = 31'(32'h100 + i);
      wr_q.push_back(wr(1, 0, 0, 5'(i), {1'b1, 31'(32'h100 + i)}));
      tick();
    end
    flush_req = 1'b1;
    issue_index = 5'd9; issue_tag = 31'h33;
    @(negedge clk);
    chk("flush_req_cycle", {issue_ready, busy, tbl_write_enable}, 3'b000);
    for (int i = 0; i < NW; i++) wr_q.push_back(wr(0, 0, 1, 5'(i), 32'h0));
    tick();
    flush_req = 1'b0;
    repeat (NW) tick();
    @(negedge clk);
    chk("done_cycle", {flush_done, busy, issue_ready, tbl_write_enable}, 4'b1000);
    wr_q.push_back(wr(1, 0, 0, 5'd9, {1'b1, 31'h33}));
    tick();
    @(negedge clk);
    chk("done_pulse_width", {flush_done, busy}, 2'b00);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < NW; i++)
      do_lookup(5'(i), (i == 9) ? {1'b1, 31'h33} : 32'h0);

    // Reset while the flush counter sits at 10; lookups stall meanwhile.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i <= 10; i++) wr_q.push_back(wr(0, 0, 1, 5'(i), 32'h0));
    for (int i = 0; i <= 10; i++) lk_q.push_back({1'b1, 31'h0});
    lookup_valid = 1'b1; lookup_index = 5'd9;
    repeat (10) tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    lookup_valid = 1'b0;
    #1;
    chk("reset_mid_flush", {busy, flush_done, tbl_write_enable}, 3'b000);
    tick();
    reset = 1'b0;
    fd_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (flush_done) fd_count++;
    end
    chk("no_flush_done_after_reset", 64'(fd_count), 64'd0);
    tick();
    for (int i = 0; i < NW; i++) do_lookup(5'(i), 32'h0);

    // Disabled lookup with floating table bus.
    lookup_valid = 1'b0;
    @(negedge clk);
    chk("lookup_disabled", {lookup_pending, lookup_tag}, 32'h0);
    chk("lookup_disabled_no_x", 64'($isunknown({lookup_pending, lookup_tag})), 64'd0);
    tick();
    tick();
    chk("write_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("lookup_queue_drained", 64'(lk_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
